nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit add/subtract engine that drives the team's existing four_bit_rca one nibble per clock.
- It sits directly upstream of the RCA: it slices operands into nibbles, presents A/B/Cin, and captures S/Cout.
- The nibble carry is held in a flop between cycles.
- Subtraction is two's complement: complement B, Cin=1.

---
 rtl/nibble_serial_adder_pkg.sv | 18 +
 rtl/four_bit_rca.sv | 21 ++
 rtl/nibble_serial_adder.sv | 108 ++++++++++
 tb/tb_nibble_serial_adder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial add/subtract engine:
// slice width, FSM state encoding and the nibble-index width helper.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the nibble index register; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/four_bit_rca.sv
// Purely combinational 4-bit ripple-carry adder built from full-adder cells.
module four_bit_rca (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    always_comb begin
        logic c;
        c = Cin;
        S = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            S[i] = A[i] ^ B[i] ^ c;
            c    = (A[i] & B[i]) | (A[i] & c) | (B[i] & c);
        end
        Cout = c;
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle add/subtract engine: feeds one nibble per clock through a shared
// four_bit_rca, holding the inter-nibble carry in a flop.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      sub,
    input  logic [4*NIBBLES-1:0]      a,
    input  logic [4*NIBBLES-1:0]      b,
    output logic                      busy,
    output logic                      done,
    output logic [4*NIBBLES-1:0]      sum,
    output logic                      cout,
    output logic                      ovf
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = idx_width(NIBBLES);

    state_t                state, state_nx;
    logic [W-1:0]          a_r, b_r;
    logic [IW-1:0]         idx;
    logic                  carry;
    logic                  last;
    logic [NIBBLE_W-1:0]   nib_a, nib_b, rca_s;
    logic                  rca_cout;

    assign last  = (idx == IW'(NIBBLES - 1));
    assign nib_a = a_r[NIBBLE_W*idx +: NIBBLE_W];
    assign nib_b = b_r[NIBBLE_W*idx +: NIBBLE_W];

    four_bit_rca u_rca (
        .A    (nib_a),
        .B    (nib_b),
        .Cin  (carry),
        .S    (rca_s),
        .Cout (rca_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (last)  state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Subtraction is folded into the operand load: B is complemented and the
    // carry seeded with 1, so RUN is identical for add and subtract.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    a_r   <= a;
                    b_r   <= sub ? ~b : b;
                    carry <= sub;
                    idx   <= '0;
                    sum   <= '0;
                    cout  <= 1'b0;
                    ovf   <= 1'b0;
                end
                ST_RUN: begin
                    sum[NIBBLE_W*idx +: NIBBLE_W] <= rca_s;
                    carry <= rca_cout;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        cout <= rca_cout;
                        ovf  <= (a_r[W-1] == b_r[W-1]) && (rca_s[NIBBLE_W-1] != a_r[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector bench for nibble_serial_adder with NIBBLES=4.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a, b;
    logic        busy, done;
    logic [15:0] sum;
    logic        cout, ovf;

    int total = 0;
    int bad   = 0;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble the inputs right after the start edge,
    // then wait (bounded) for done and check latency, busy span and result.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic sv, input logic [15:0] es, input logic ec, input logic eo);
        int  lat;
        int  busy_n;
        bit  seen;
        @(negedge clk);
        a = av; b = bv; sub = sv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~av; b = bv ^ 16'h5A5A; sub = ~sv;
        busy_n = busy ? 1 : 0;
        lat = 0;
        seen = 0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_n++;
            if (done) seen = 1;
        end
        check({tag, " latency"}, lat, 4);
        check({tag, " busy_cycles"}, busy_n, 5);
        check({tag, " sum"}, sum, es);
        check({tag, " cout"}, cout, ec);
        check({tag, " ovf"}, ovf, eo);
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, done, 0);
        check({tag, " busy_idle"}, busy, 0);
        @(posedge clk); #1;
        check({tag, " sum_held"}, sum, es);
    endtask

    initial begin
        int dones;
        rst_n = 1'b0; start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h4321;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst sum", sum, 0);
        check("rst cout", cout, 0);
        check("rst ovf", ovf, 0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        run_op("zero",     16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_op("ripple",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("nib_carry",16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op("pos_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("neg_ovf",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("sub_5_3",  16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_op("sub_3_5",  16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Start re-asserted with other operands while RUN is in progress.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("ignore_start done_count", dones, 1);
        check("ignore_start sum", sum, 16'h2345);
        check("ignore_start cout", cout, 0);

        // Reset asserted at the second RUN edge aborts the operation.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort sum", sum, 0);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        check("abort no_done", dones, 0);

        run_op("after_abort", 16'h1234, 16'h0234, 1'b1, 16'h1000, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
